// File: rtl/fetch_seq.sv
// Program-counter and instruction-fetch sequencer: IDLE -> FETCH -> EXEC loop with fetch timeout.
// Optional misaligned-redirect trap enabled by defining FETCH_SEQ_MISALIGN_TRAP_EN.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_4180,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] npc_t,
  input  logic [31:0] npc_in,
  input  logic        stall,
  output logic [31:0] instr_count,
  output logic        fetch_err,
  output logic        trap,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ERR
  } state_t;

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   wait_cnt;
  logic            timeout_hit;
  logic            commit;
  logic            misaligned;
  logic [31:0]     commit_pc;

  assign timeout_hit = (wait_cnt == WW'(TIMEOUT - 1));
  assign commit      = (state == S_EXEC) && !stall;
  assign misaligned  = |npc_in[1:0];
  // Masking keeps every npc_in bit in use; the low bits only matter for the trap decision.
  assign commit_pc   = (TRAP_EN && misaligned) ? TRAP_PC : (npc_in & 32'hFFFF_FFFC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_nxt = S_EXEC;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_EXEC:  if (!stall) state_nxt = S_FETCH;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == S_FETCH);
    instr_valid = (state == S_EXEC);
    imem_addr   = pc;
    npc_t       = pc + 32'd4;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_count <= '0;
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (state == S_FETCH) begin
        // An ack on the last allowed cycle wins over the timeout.
        if (imem_ack) begin
          instr    <= imem_rdata;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + WW'(1);
          if (timeout_hit) begin
            fetch_err <= 1'b1;
          end
        end
      end else begin
        wait_cnt <= '0;
      end
      if (commit) begin
        pc          <= commit_pc;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trap <= 1'b0;
      epc  <= '0;
    end else begin
      trap <= commit && misaligned;
      if (commit && misaligned) begin
        epc <= pc;
      end
    end
  end
`else
  assign trap = 1'b0;
  assign epc  = '0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus randomized instruction transactions
// checked against a transaction-level model of PC, instruction, retire count and trap state.
module tb_fetch_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_4180;
  localparam int unsigned TIMEOUT  = 16;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] npc_t;
  logic [31:0] npc_in = '0;
  logic        stall = 1'b0;
  logic [31:0] instr_count;
  logic        fetch_err;
  logic        trap;
  logic [31:0] epc;

  fetch_seq #(
    .RESET_PC(RESET_PC),
    .TRAP_PC (TRAP_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .npc_t      (npc_t),
    .npc_in     (npc_in),
    .stall      (stall),
    .instr_count(instr_count),
    .fetch_err  (fetch_err),
    .trap       (trap),
    .epc        (epc)
  );

  always #5 clock = ~clock;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_count;
  logic [31:0] exp_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_reset();
    exp_pc    = RESET_PC;
    exp_instr = '0;
    exp_count = '0;
    exp_epc   = '0;
  endtask

  // Leaves the bench at a falling edge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    reset      = 1'b1;
    imem_ack   = 1'b0;
    stall      = 1'b0;
    npc_in     = '0;
    imem_rdata = '0;
    repeat (2) tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_req", imem_req, 32'd0);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_err", fetch_err, 32'd0);
    check("rst_trap", trap, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_npc_t", npc_t, RESET_PC + 32'd4);
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  // One instruction: ack after d wait cycles, s stall cycles, then commit npc.
  task automatic do_instr(input int d, input int s, input logic [31:0] npc, input logic [31:0] rd);
    logic mis;
    for (int k = 0; k <= d; k++) begin
      check("f_req", imem_req, 32'd1);
      check("f_addr", imem_addr, exp_pc);
      check("f_valid", instr_valid, 32'd0);
      check("f_instr_hold", instr, exp_instr);
      check("f_err", fetch_err, 32'd0);
      if (k > 0) check("f_trap", trap, 32'd0);
      imem_ack   = (k == d);
      imem_rdata = (k == d) ? rd : $urandom;
      stall      = 1'($urandom);
      npc_in     = $urandom;
      tick();
    end
    imem_ack  = 1'b0;
    exp_instr = rd;
    check("e_valid", instr_valid, 32'd1);
    check("e_req", imem_req, 32'd0);
    check("e_instr", instr, exp_instr);
    check("e_pc", pc, exp_pc);
    check("e_npc_t", npc_t, exp_pc + 32'd4);
    check("e_trap", trap, 32'd0);
    for (int j = 0; j < s; j++) begin
      stall      = 1'b1;
      npc_in     = $urandom;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      tick();
      check("s_valid", instr_valid, 32'd1);
      check("s_pc", pc, exp_pc);
      check("s_instr", instr, exp_instr);
      check("s_count", instr_count, exp_count);
    end
    stall    = 1'b0;
    imem_ack = 1'($urandom);
    npc_in   = npc;
    tick();
    mis = |npc[1:0];
    if (TRAP_EN && mis) begin
      exp_epc = exp_pc;
      exp_pc  = TRAP_PC;
    end else begin
      exp_pc = npc & 32'hFFFF_FFFC;
    end
    exp_count = exp_count + 32'd1;
    imem_ack  = 1'b0;
    check("c_pc", pc, exp_pc);
    check("c_count", instr_count, exp_count);
    check("c_req", imem_req, 32'd1);
    check("c_trap", trap, (TRAP_EN && mis) ? 32'd1 : 32'd0);
    check("c_epc", epc, exp_epc);
  endtask

  initial begin
    logic [31:0] npc;
    int          sel;

    do_reset();

    // Back-to-back sequential fetch with same-cycle ack.
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
      do_instr(0, 0, exp_pc + 32'd4, 32'h2008_0005);
    end
    check("seq_count", instr_count, 32'd3);

    do_instr(3, 0, exp_pc + 32'd4, $urandom);
    do_instr(0, 5, 32'h0000_3040, $urandom);
    check("stall_commit_pc", pc, 32'h0000_3040);

    do_instr(0, 0, 32'h0000_3022, $urandom);
    check("misalign_pc", pc, TRAP_EN ? TRAP_PC : 32'h0000_3020);

    // Ack on the final allowed wait cycle must still be accepted.
    do_instr(int'(TIMEOUT) - 1, 1, exp_pc + 32'd4, $urandom);

    // Fetch timeout into the terminal error state.
    do_reset();
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      check("to_req", imem_req, 32'd1);
      check("to_err_low", fetch_err, 32'd0);
      imem_ack = 1'b0;
      tick();
    end
    check("to_req_off", imem_req, 32'd0);
    check("to_err", fetch_err, 32'd1);
    check("to_valid", instr_valid, 32'd0);
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1;
      stall    = 1'($urandom);
      tick();
      check("err_req", imem_req, 32'd0);
      check("err_sticky", fetch_err, 32'd1);
    end
    do_reset();
    check("post_err_pc", pc, 32'h0000_3000);

    // Asynchronous reset during a FETCH wait, with a late ack afterwards.
    do_instr(1, 0, 32'h0000_5000, $urandom);
    imem_ack = 1'b0;
    repeat (2) tick();
    check("pre_abort_req", imem_req, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_req", imem_req, 32'd0);
    check("abort_pc", pc, RESET_PC);
    check("abort_count", instr_count, 32'd0);
    @(negedge clock);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    imem_ack = 1'b0;
    check("late_ack_instr", instr, 32'd0);
    check("late_ack_addr", imem_addr, RESET_PC);
    check("late_ack_req", imem_req, 32'd1);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       npc = exp_pc + 32'd4;
        1:       npc = $urandom;
        2:       npc = (exp_pc + 32'd4) | 32'($urandom_range(0, 3));
        default: npc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      endcase
      do_instr($urandom_range(0, 6), $urandom_range(0, 3), npc, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
